// File: rtl/spi_frame_arb_if.sv
// Request/acknowledge and serializer-side signal bundle for spi_frame_arb.
//
// Handshake: a requester raises reqN with dataN and holds both stable until
// ackN. ackN is a one-cycle pulse and err is valid only in that same cycle.
// The requester drops reqN on the edge after ackN. A reqN still high when the
// arbiter next samples in IDLE counts as a fresh request. dataN is sampled
// only at the grant edge.
interface spi_frame_arb_if #(
    parameter int DW = 24
);
    logic          req0;
    logic [DW-1:0] data0;
    logic          ack0;
    logic          req1;
    logic [DW-1:0] data1;
    logic          ack1;
    logic          ser_rst;
    logic [DW-1:0] ser_data;
    logic          ser_sync;
    logic          busy;
    logic          err;
    logic          last_gnt;

    // Arbiter side
    modport slave (
        input  req0, data0, req1, data1, ser_sync,
        output ack0, ack1, ser_rst, ser_data, busy, err, last_gnt
    );

    // Requester / serializer side
    modport master (
        output req0, data0, req1, data1, ser_sync,
        input  ack0, ack1, ser_rst, ser_data, busy, err, last_gnt
    );
endinterface

// File: rtl/spi_frame_arb.sv
// Two-requester round-robin arbiter and frame sequencer for a 24-bit SPI
// parallel-to-serial serializer. The granted word is latched onto the
// serializer's parallel input, the serializer reset is released for exactly
// one frame, then re-asserted and the requester is acknowledged. The
// serializer sync is checked against the expected frame timing.
module spi_frame_arb #(
    parameter int DW        = 24,
    parameter int FRAME_LEN = 24,
    parameter int GAP_CYC   = 2
) (
    input  logic          sclk,
    input  logic          seq_rst,
    spi_frame_arb_if.slave bus,
    output logic [1:0]    state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam int RCW = $clog2(FRAME_LEN + 1);
    localparam int GCW = $clog2(GAP_CYC + 1);

    localparam logic [RCW-1:0] RUN_LAST  = RCW'(FRAME_LEN);
    localparam logic [RCW-1:0] RUN_CHK0  = RCW'(2);
    localparam logic [RCW-1:0] RUN_ONE   = RCW'(1);
    localparam logic [GCW-1:0] GAP_LAST  = GCW'(GAP_CYC);
    localparam logic [GCW-1:0] GAP_ONE   = GCW'(1);

    state_t          state_q,    state_d;
    logic            ser_rst_q,  ser_rst_d;
    logic [DW-1:0]   ser_data_q, ser_data_d;
    logic            ack0_q,     ack0_d;
    logic            ack1_q,     ack1_d;
    logic            err_q,      err_d;
    logic            last_gnt_q, last_gnt_d;
    logic            sync_bad_q, sync_bad_d;
    logic [RCW-1:0]  run_cnt_q,  run_cnt_d;
    logic [GCW-1:0]  gap_cnt_q,  gap_cnt_d;
    logic            gnt_idx;

    // State and datapath registers; reset drops the serializer reset at once
    // and abandons any frame in flight without an ack.
    always_ff @(posedge sclk or negedge seq_rst) begin
        if (!seq_rst) begin
            state_q    <= IDLE;
            ser_rst_q  <= 1'b0;
            ser_data_q <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            err_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            sync_bad_q <= 1'b0;
            run_cnt_q  <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            ser_rst_q  <= ser_rst_d;
            ser_data_q <= ser_data_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            err_q      <= err_d;
            last_gnt_q <= last_gnt_d;
            sync_bad_q <= sync_bad_d;
            run_cnt_q  <= run_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    // Next-state logic: arbitration in IDLE, one load cycle, a counted frame
    // with sync checking, then a gap with the serializer held in reset.
    always_comb begin
        state_d    = state_q;
        ser_rst_d  = ser_rst_q;
        ser_data_d = ser_data_q;
        ack0_d     = ack0_q;
        ack1_d     = ack1_q;
        err_d      = err_q;
        last_gnt_d = last_gnt_q;
        sync_bad_d = sync_bad_q;
        run_cnt_d  = run_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        // On a tie the requester that did not win last time goes next.
        gnt_idx    = (bus.req0 && bus.req1) ? ~last_gnt_q : bus.req1;

        case (state_q)
            IDLE: begin
                ser_rst_d = 1'b0;
                if (bus.req0 || bus.req1) begin
                    ser_data_d = gnt_idx ? bus.data1 : bus.data0;
                    last_gnt_d = gnt_idx;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                // Serializer has seen ser_data while in reset; release it now.
                ser_rst_d  = 1'b1;
                run_cnt_d  = RUN_ONE;
                sync_bad_d = 1'b0;
                state_d    = RUN;
            end
            RUN: begin
                // Sync may still be high on the first edge after release;
                // from the second edge to the last it must stay low.
                if (run_cnt_q >= RUN_CHK0 && bus.ser_sync) begin
                    sync_bad_d = 1'b1;
                end
                if (run_cnt_q == RUN_LAST) begin
                    // Re-assert reset on the same edge the serializer raises
                    // sync, so it never starts a second frame.
                    ser_rst_d = 1'b0;
                    ack0_d    = ~last_gnt_q;
                    ack1_d    = last_gnt_q;
                    err_d     = sync_bad_q | bus.ser_sync;
                    gap_cnt_d = GAP_ONE;
                    state_d   = GAP;
                end else begin
                    run_cnt_d = run_cnt_q + RUN_ONE;
                end
            end
            GAP: begin
                ser_rst_d = 1'b0;
                ack0_d    = 1'b0;
                ack1_d    = 1'b0;
                err_d     = 1'b0;
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.ser_rst  = ser_rst_q;
    assign bus.ser_data = ser_data_q;
    assign bus.ack0     = ack0_q;
    assign bus.ack1     = ack1_q;
    assign bus.err      = err_q;
    assign bus.last_gnt = last_gnt_q;
    assign bus.busy     = (state_q != IDLE);
    assign state_o      = state_q;

endmodule

// File: doc/spi_frame_arb.md
Name: spi_frame_arb

Overview:
- Two-requester round-robin arbiter and frame sequencer in front of the 24-bit SPI parallel-to-serial serializer.
- Latches the granted requester's word onto the serializer's parallel input.
- Releases the serializer's active-low reset for exactly one frame, then re-asserts it and acknowledges the requester.
- Enforces an inter-frame sync-high gap and checks the serializer's sync against the expected frame timing.

Parameters:
- DW, 24, frame/data width in bits.
- FRAME_LEN, 24, clocks the serializer reset is held released per frame; reset edge to sync rising edge.
- GAP_CYC, 2, clocks in GAP with serializer held in reset before returning to IDLE; must be >=1.

Ports:
- sclk  in  1  system/SPI clock; all logic on posedge.
- seq_rst  in  1  reset, asynchronous, active-low.
- req0  in  1  requester 0 request; held with data0 until ack0.
- data0  in  DW  requester 0 word.
- ack0  out  1  one-cycle completion pulse to requester 0.
- req1  in  1  requester 1 request.
- data1  in  DW  requester 1 word.
- ack1  out  1  one-cycle completion pulse to requester 1.
- ser_rst  out  1  to serializer reset (active-low); 0 holds it idle (sync=1).
- ser_data  out  DW  to serializer parallel data.
- ser_sync  in  1  serializer sync, 0 while shifting.
- busy  out  1  high in any state other than IDLE.
- err  out  1  qualifies ack0/ack1; 1 = frame sync check failed.
- last_gnt  out  1  index of last granted requester.

Behaviour:
- Reset (seq_rst=0, async): state=IDLE, ser_rst=0, ser_data=0, ack0=ack1=0, err=0, busy=0, last_gnt=1 (req0 wins the first tie), run_cnt=0, gap_cnt=0.
- Reset mid-frame: ser_rst drops immediately and the frame is abandoned; no ack is issued.
- States: IDLE, LOAD, RUN, GAP.
- IDLE:
  - ser_rst=0.
  - Only one req high: grant it.
  - Both high: grant the index != last_gnt.
  - On grant: ser_data<=granted data, last_gnt<=index, go to LOAD.
  - No req: stay in IDLE.
- LOAD:
  - One cycle with ser_rst=0 so the serializer loads ser_data.
  - Next edge: ser_rst<=1, run_cnt<=1, go to RUN.
- RUN:
  - ser_rst=1; run_cnt increments each edge.
  - With E0 = the edge that set ser_rst=1, ser_sync sampled at edges E2..E(FRAME_LEN) must be 0; any 1 sets an internal sync_bad flag.
  - At edge E(FRAME_LEN), i.e. run_cnt==FRAME_LEN:
    - ser_rst<=0 (same edge the serializer raises sync, so no spurious sync-low cycle).
    - ack of the granted index<=1 for one cycle; err<=sync_bad.
    - gap_cnt<=1; go to GAP.
- GAP:
  - ser_rst=0.
  - ack and err clear after one cycle.
  - When gap_cnt==GAP_CYC, go to IDLE; else gap_cnt increments.
- ser_data stays stable from grant until the next grant; it is never changed while ser_rst=1.
- Requester rules:
  - Keep req and data stable until ack.
  - Drop req on the edge after ack.
  - A req still high when IDLE samples it is a new request.
  - data is sampled only at grant.
- Requests arriving in LOAD/RUN/GAP wait; there is no queueing beyond the held req.
- Timing from grant edge T0: LOAD at T0, RUN from T1, ack at T(1+FRAME_LEN)=T25, GAP exits at T27; earliest next grant is T28.
- Widths: run_cnt and gap_cnt are $clog2(FRAME_LEN+1) and $clog2(GAP_CYC+1) bits; neither wraps, since each is cleared on state entry.

Test Plan:
- Single request: req0=1, data0=24'hA5A5A5 at T0 -> ser_data=A5A5A5 at T0; ser_rst rises at T1, falls at T25; ack0 high only in the cycle after T25; err=0; busy high T0..T27.
- Tie: req0=req1=1 from reset -> grant order 0,1,0 with acks 28 clocks apart; last_gnt toggles.
- Fairness under hog: req0 held continuously, req1 asserted mid-frame -> req1 granted at the very next IDLE sample.
- Sync fault: tie ser_sync=1 -> ack asserted at T25 with err=1; err=0 on the following frame with a good model.
- Reset mid-RUN: seq_rst=0 at T10 -> ser_rst=0, busy=0, no ack; after release, a pending req0 is re-granted and completes normally.
- GAP_CYC=1 build: ack at T25, IDLE at T26, next grant at T27.
